poly_tone_gen: RTL and testbench

Multi-voice phase-accumulator tone generator for the synth audio path; the parametrised successor to the single-voice square generator. Holds VOICES independent phase accumulators, each with its own increment, waveform mode and gate, all programmed through a register-write port. Advances every voice once per sample period and registers a signed mixed sum for the downstream audio codec interface.

---
 rtl/poly_tone_gen.sv | 182 ++++++++++++++++++
 tb/tb_poly_tone_gen.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_tone_gen.sv
// -----------------------------------------------------------------------------
// poly_tone_gen
//
// Multi-voice phase-accumulator tone generator. Each of VOICES voices has its
// own phase increment, waveform mode and gate, all loaded through a single
// register-write port. Once per sample period (SAMPLE_DIV clocks) every gated
// voice advances its phase, and the signed sum of all voice samples is
// registered onto audio_out_o for the codec interface.
//
// Ports
//   clock_i        system clock, all logic on the rising edge
//   reset_i        synchronous, active-high reset
//   wr_en_i        write strobe for one voice's control registers
//   wr_voice_i     target voice index (indices >= VOICES are ignored)
//   wr_inc_i       phase increment per sample
//   wr_mode_i      0 square, 1 saw, 2 triangle, 3 mute
//   wr_gate_i      voice gate (1 = sounding)
//   sample_tick_o  one-cycle pulse, high in the last cycle of each period
//   audio_out_o    signed mixed sample, updated on the edge ending a tick cycle
//   dbg_phase_o    all phase accumulators, voice v at [v*PHASE_BITS +: PHASE_BITS]
//
// Handshake: there is no back-pressure. A write is accepted on every rising
// edge where wr_en_i is 1 and wr_voice_i names an existing voice; the sample
// stream is a free-running pulse with no ready.
// -----------------------------------------------------------------------------
module poly_tone_gen #(
    parameter int VOICES     = 4,
    parameter int PHASE_BITS = 32,
    parameter int OUT_BITS   = 8,
    parameter int SAMPLE_DIV = 1042,
    localparam int VW = (VOICES > 1) ? $clog2(VOICES) : 1,
    localparam int AW = OUT_BITS + $clog2(VOICES)
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic                         wr_en_i,
    input  logic [VW-1:0]                wr_voice_i,
    input  logic [PHASE_BITS-1:0]        wr_inc_i,
    input  logic [1:0]                   wr_mode_i,
    input  logic                         wr_gate_i,
    output logic                         sample_tick_o,
    output logic signed [AW-1:0]         audio_out_o,
    output logic [VOICES*PHASE_BITS-1:0] dbg_phase_o
);

    localparam int CW = $clog2(SAMPLE_DIV);
    localparam int M  = PHASE_BITS - 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(SAMPLE_DIV - 1);

    // Full-scale sample codes and the sign bit used for offset conversion.
    localparam logic [OUT_BITS-1:0] S_MAX    = {1'b0, {(OUT_BITS-1){1'b1}}};
    localparam logic [OUT_BITS-1:0] S_MIN    = {1'b1, {(OUT_BITS-1){1'b0}}};
    localparam logic [OUT_BITS-1:0] SIGN_BIT = {1'b1, {(OUT_BITS-1){1'b0}}};

    typedef enum logic [1:0] {
        MODE_SQUARE = 2'd0,
        MODE_SAW    = 2'd1,
        MODE_TRI    = 2'd2,
        MODE_MUTE   = 2'd3
    } mode_e;

    // Sample divider
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // Per-voice control and phase
    logic [PHASE_BITS-1:0] inc_q   [VOICES];
    logic [PHASE_BITS-1:0] inc_d   [VOICES];
    logic [PHASE_BITS-1:0] phase_q [VOICES];
    logic [PHASE_BITS-1:0] phase_d [VOICES];
    mode_e                 mode_q  [VOICES];
    mode_e                 mode_d  [VOICES];
    logic                  gate_q  [VOICES];
    logic                  gate_d  [VOICES];

    // Waveform and mixer
    logic [OUT_BITS-1:0]        tri_u [VOICES];
    logic signed [OUT_BITS-1:0] samp  [VOICES];
    logic signed [AW-1:0]       mix_sum;
    logic signed [AW-1:0]       audio_q, audio_d;

    // -------------------------------------------------------------------------
    // Divider: tick_q is registered so it is high exactly while cnt_q sits at
    // its last value; the edge that ends that cycle is the "tick edge".
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_d  = (cnt_q == DIV_LAST) ? '0 : cnt_q + 1'b1;
        tick_d = (cnt_d == DIV_LAST);
    end

    // -------------------------------------------------------------------------
    // Waveform generation from the current (pre-update) phase.
    // Subtracting 2^(OUT_BITS-1) from an unsigned OUT_BITS code is the same as
    // flipping its MSB, which is how saw and triangle are offset to signed.
    // -------------------------------------------------------------------------
    always_comb begin
        for (int v = 0; v < VOICES; v++) begin
            tri_u[v] = phase_q[v][M-1 -: OUT_BITS];
            if (phase_q[v][M]) begin
                tri_u[v] = ~phase_q[v][M-1 -: OUT_BITS];
            end
            samp[v] = '0;
            if (gate_q[v]) begin
                case (mode_q[v])
                    MODE_SQUARE: samp[v] = phase_q[v][M] ? $signed(S_MIN) : $signed(S_MAX);
                    MODE_SAW:    samp[v] = $signed(phase_q[v][M -: OUT_BITS] ^ SIGN_BIT);
                    MODE_TRI:    samp[v] = $signed(tri_u[v] ^ SIGN_BIT);
                    default:     samp[v] = '0;
                endcase
            end
        end
    end

    // Exact-width sum: AW has room for VOICES full-scale samples.
    always_comb begin
        mix_sum = '0;
        for (int v = 0; v < VOICES; v++) begin
            mix_sum = mix_sum + AW'(samp[v]);
        end
        audio_d = tick_q ? mix_sum : audio_q;
    end

    // -------------------------------------------------------------------------
    // Voice next-state. The tick accumulate is computed from the old settings
    // first; a coincident write then overrides control registers and, when it
    // clears the phase, the clear takes precedence over the accumulate.
    // -------------------------------------------------------------------------
    always_comb begin
        for (int v = 0; v < VOICES; v++) begin
            inc_d[v]   = inc_q[v];
            mode_d[v]  = mode_q[v];
            gate_d[v]  = gate_q[v];
            phase_d[v] = phase_q[v];
            if (tick_q && gate_q[v]) begin
                phase_d[v] = phase_q[v] + inc_q[v];
            end
            // Only indices 0..VOICES-1 can match, so out-of-range writes drop.
            if (wr_en_i && (wr_voice_i == VW'(v))) begin
                inc_d[v]  = wr_inc_i;
                mode_d[v] = mode_e'(wr_mode_i);
                gate_d[v] = wr_gate_i;
                // Gate off clears; gate on from off restarts at 0; gate held
                // on keeps phase so a retune is glitch-free.
                if (!wr_gate_i || !gate_q[v]) begin
                    phase_d[v] = '0;
                end
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            audio_q <= '0;
            for (int v = 0; v < VOICES; v++) begin
                inc_q[v]   <= '0;
                mode_q[v]  <= MODE_SQUARE;
                gate_q[v]  <= 1'b0;
                phase_q[v] <= '0;
            end
        end else begin
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            audio_q <= audio_d;
            for (int v = 0; v < VOICES; v++) begin
                inc_q[v]   <= inc_d[v];
                mode_q[v]  <= mode_d[v];
                gate_q[v]  <= gate_d[v];
                phase_q[v] <= phase_d[v];
            end
        end
    end

    assign sample_tick_o = tick_q;
    assign audio_out_o   = audio_q;

    for (genvar g = 0; g < VOICES; g++) begin : g_dbg
        assign dbg_phase_o[g*PHASE_BITS +: PHASE_BITS] = phase_q[g];
    end

endmodule

// File: tb/tb_poly_tone_gen.sv
// -----------------------------------------------------------------------------
// Testbench for poly_tone_gen (VOICES=4, PHASE_BITS=16, OUT_BITS=8,
// SAMPLE_DIV=4) plus a VOICES=3 instance for the out-of-range write case.
// A behavioural model of the voices runs alongside the main instance and is
// compared every cycle; directed tone tables and corner sequences add fixed
// expected sample values.
// -----------------------------------------------------------------------------
module tb_poly_tone_gen;

    localparam int NV  = 4;
    localparam int PB  = 16;
    localparam int OB  = 8;
    localparam int DIV = 4;
    localparam int AW  = 10;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;

    // main instance
    logic                 wr_en    = 1'b0;
    logic [1:0]           wr_voice = '0;
    logic [PB-1:0]        wr_inc   = '0;
    logic [1:0]           wr_mode  = '0;
    logic                 wr_gate  = 1'b0;
    logic                 sample_tick;
    logic signed [AW-1:0] audio;
    logic [NV*PB-1:0]     dbg_phase;

    // three-voice instance
    logic                 wr_en3    = 1'b0;
    logic [1:0]           wr_voice3 = '0;
    logic [PB-1:0]        wr_inc3   = '0;
    logic [1:0]           wr_mode3  = '0;
    logic                 wr_gate3  = 1'b0;
    logic                 tick3;
    logic signed [AW-1:0] audio3;
    logic [3*PB-1:0]      dbg3;

    poly_tone_gen #(.VOICES(NV), .PHASE_BITS(PB), .OUT_BITS(OB), .SAMPLE_DIV(DIV)) u_dut (
        .clock_i(clk), .reset_i(rst), .wr_en_i(wr_en), .wr_voice_i(wr_voice),
        .wr_inc_i(wr_inc), .wr_mode_i(wr_mode), .wr_gate_i(wr_gate),
        .sample_tick_o(sample_tick), .audio_out_o(audio), .dbg_phase_o(dbg_phase)
    );

    poly_tone_gen #(.VOICES(3), .PHASE_BITS(PB), .OUT_BITS(OB), .SAMPLE_DIV(DIV)) u_dut3 (
        .clock_i(clk), .reset_i(rst), .wr_en_i(wr_en3), .wr_voice_i(wr_voice3),
        .wr_inc_i(wr_inc3), .wr_mode_i(wr_mode3), .wr_gate_i(wr_gate3),
        .sample_tick_o(tick3), .audio_out_o(audio3), .dbg_phase_o(dbg3)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [AW-1:0] exp_q[$];

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_inc[NV], m_mode[NV], m_gate[NV], m_phase[NV];
    int m_cnt, m_tick, m_audio;

    function automatic int wave(input int v);
        int p, t;
        p = m_phase[v];
        if (m_gate[v] == 0) return 0;
        case (m_mode[v])
            0: return (p < 32768) ? 127 : -128;
            1: return p / 256 - 128;
            2: begin
                t = (p % 32768) / 128;
                return (p < 32768) ? t - 128 : (255 - t) - 128;
            end
            default: return 0;
        endcase
    endfunction

    task automatic model_edge();
        int s, v;
        if (rst) begin
            for (int i = 0; i < NV; i++) begin
                m_inc[i] = 0; m_mode[i] = 0; m_gate[i] = 0; m_phase[i] = 0;
            end
            m_cnt = 0; m_tick = 0; m_audio = 0;
        end else begin
            if (m_tick != 0) begin
                s = 0;
                for (int i = 0; i < NV; i++) s += wave(i);
                m_audio = s;
                for (int i = 0; i < NV; i++)
                    if (m_gate[i] != 0) m_phase[i] = (m_phase[i] + m_inc[i]) % 65536;
            end
            if (wr_en) begin
                v = int'(wr_voice);
                if (v < NV) begin
                    if (!wr_gate || m_gate[v] == 0) m_phase[v] = 0;
                    m_inc[v]  = int'(wr_inc);
                    m_mode[v] = int'(wr_mode);
                    m_gate[v] = int'(wr_gate);
                end
            end
            m_cnt  = (m_cnt + 1) % DIV;
            m_tick = (m_cnt == DIV - 1) ? 1 : 0;
        end
    endtask

    // ---------------- driver tasks ----------------
    // One clock: the model sees the same inputs the DUT sampled, then outputs
    // are compared 1 time unit after the edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        wr_en  = 1'b0;
        wr_en3 = 1'b0;
        check("tick", sample_tick, m_tick);
        check("audio", audio, m_audio);
        for (int v = 0; v < NV; v++)
            check($sformatf("phase%0d", v), dbg_phase[v*PB +: PB], m_phase[v]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;
    endtask

    task automatic write_main(input int v, input int inc, input int mode, input bit gate);
        wr_en    = 1'b1;
        wr_voice = 2'(v);
        wr_inc   = 16'(inc);
        wr_mode  = 2'(mode);
        wr_gate  = gate;
        cycle();
    endtask

    task automatic wait_tick_high();
        int n;
        n = 0;
        while (sample_tick !== 1'b1 && n < 2 * DIV) begin
            cycle();
            n++;
        end
        check("tick_seen", sample_tick, 1);
    endtask

    task automatic next_sample();
        wait_tick_high();
        cycle();
    endtask

    task automatic expect_samples(input string name);
        logic [AW-1:0] e;
        while (exp_q.size() > 0) begin
            next_sample();
            e = exp_q.pop_front();
            check(name, audio, $signed(e));
        end
    endtask

    // ---------------- directed tone table ----------------
    typedef struct {
        int voice;
        int inc;
        int mode;
        int exp[17];
    } tone_vec_t;

    tone_vec_t vecs[3];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        vecs[0].voice = 0; vecs[0].inc = 'h4000; vecs[0].mode = 0;
        vecs[0].exp = '{127, 127, -128, -128, 127, 127, -128, -128,
                        127, 127, -128, -128, 127, 127, -128, -128, 127};
        vecs[1].voice = 1; vecs[1].inc = 'h1000; vecs[1].mode = 1;
        vecs[1].exp = '{-128, -112, -96, -80, -64, -48, -32, -16,
                        0, 16, 32, 48, 64, 80, 96, 112, -128};
        vecs[2].voice = 2; vecs[2].inc = 'h2000; vecs[2].mode = 2;
        vecs[2].exp = '{-128, -64, 0, 64, 127, 63, -1, -65,
                        -128, -64, 0, 64, 127, 63, -1, -65, -128};

        // Reset and divider timing
        do_reset();
        check("reset_audio", audio, 0);
        check("reset_tick", sample_tick, 0);
        n = 0;
        while (sample_tick !== 1'b1 && n < 10) begin
            cycle();
            n++;
        end
        check("first_tick_delay", n, DIV - 1);
        repeat (12) cycle();
        check("idle_audio", audio, 0);

        // Single-voice tones from the table
        for (int i = 0; i < 3; i++) begin
            do_reset();
            write_main(vecs[i].voice, vecs[i].inc, vecs[i].mode, 1'b1);
            for (int k = 0; k < 17; k++) exp_q.push_back(AW'(vecs[i].exp[k]));
            expect_samples($sformatf("tone%0d", i));
        end

        // Mix extremes: align all four square phases at 0 before the first tick
        do_reset();
        for (int v = 0; v < 3; v++) write_main(v, 0, 0, 1'b1);
        wait_tick_high();
        write_main(3, 'h8000, 0, 1'b1);
        check("mix_pre", audio, 381);
        for (int v = 0; v < 3; v++) write_main(v, 'h8000, 0, 1'b1);
        exp_q.push_back(AW'(508));
        exp_q.push_back(AW'(-512));
        exp_q.push_back(AW'(508));
        exp_q.push_back(AW'(-512));
        expect_samples("mix_full");
        write_main(3, 'h8000, 3, 1'b1);
        exp_q.push_back(AW'(381));
        exp_q.push_back(AW'(-384));
        expect_samples("mix_mute3");

        // Gate off coincident with a tick
        do_reset();
        write_main(0, 'h4000, 0, 1'b1);
        write_main(1, 'h1000, 1, 1'b1);
        next_sample();
        check("gate_first", audio, -1);
        wait_tick_high();
        write_main(0, 'h4000, 0, 1'b0);
        check("gate_off_tick_audio", audio, 15);
        check("gate_off_phase0", dbg_phase[PB-1:0], 0);
        next_sample();
        check("gate_off_after", audio, -96);

        // Retune a gated voice keeps its phase
        do_reset();
        write_main(0, 'h1000, 1, 1'b1);
        exp_q.push_back(AW'(-128));
        exp_q.push_back(AW'(-112));
        exp_q.push_back(AW'(-96));
        expect_samples("retune_pre");
        write_main(0, 'h0800, 1, 1'b1);
        check("retune_phase", dbg_phase[PB-1:0], 'h3000);
        exp_q.push_back(AW'(-80));
        exp_q.push_back(AW'(-72));
        expect_samples("retune_post");

        // Out-of-range write on the three-voice build
        do_reset();
        wr_en3 = 1'b1; wr_voice3 = 2'd3; wr_inc3 = 16'h8000; wr_mode3 = 2'd0; wr_gate3 = 1'b1;
        cycle();
        repeat (8) cycle();
        check("oor_audio", audio3, 0);
        check("oor_phase", dbg3, 0);
        wr_en3 = 1'b1; wr_voice3 = 2'd2; wr_inc3 = 16'h8000; wr_mode3 = 2'd0; wr_gate3 = 1'b1;
        cycle();
        next_sample();
        check("v3_valid_audio", audio3, 127);

        // Randomized traffic against the model, with occasional mid-period reset
        do_reset();
        for (int c = 0; c < 700; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                cycle();
                rst = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                wr_en    = 1'b1;
                wr_voice = 2'($urandom_range(0, 3));
                wr_inc   = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 65535))
                                                       : 16'($urandom_range(0, 3) << 12);
                wr_mode  = 2'($urandom_range(0, 3));
                wr_gate  = ($urandom_range(0, 4) != 0);
                cycle();
            end else begin
                cycle();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
